// File: rtl/vector_group_sequencer.sv
// Vector LMUL register-group sequencer: latches vtype/vl on start and issues one beat per physical register.
// Optional stall counter enabled by defining VECTOR_SEQ_STALL_CNT_EN.
module vector_group_sequencer #(
    parameter int VLEN  = 64,
    parameter int VLENB = VLEN / 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic                    flush_i,
    input  logic                    vill_i,
    input  logic [2:0]              vsew_i,
    input  logic [2:0]              vlmul_i,
    input  logic [$clog2(VLEN):0]   vl_i,
    input  logic [4:0]              vd_i,
    input  logic [4:0]              vs1_i,
    input  logic [4:0]              vs2_i,
    output logic                    issue_valid_o,
    input  logic                    issue_ready_i,
    output logic [4:0]              vd_o,
    output logic [4:0]              vs1_o,
    output logic [4:0]              vs2_o,
    output logic [VLENB-1:0]        byte_en_o,
    output logic                    first_o,
    output logic                    last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    illegal_o,
    output logic [31:0]             stall_cnt_o
);

    localparam int VLW = $clog2(VLEN) + 1;
    localparam int LB  = $clog2(VLENB);
    localparam logic [VLW-1:0] ONE   = VLW'(1);
    localparam logic [VLW-1:0] BYTES = VLW'(VLENB);

    typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

    state_t         r_state;
    logic [2:0]     r_vsew;
    logic [2:0]     r_vlmul;
    logic [VLW-1:0] r_vl;
    logic [4:0]     r_vd;
    logic [4:0]     r_vs1;
    logic [4:0]     r_vs2;
    logic [VLW-1:0] r_idx;
    logic [VLW-1:0] r_beats;
    logic           r_illegal;

    logic [VLW-1:0]   w_eprIn;
    logic [VLW-1:0]   w_beatsIn;
    logic [4:0]       w_alignMask;
    logic             w_illegalIn;
    logic [VLW-1:0]   w_eprCur;
    logic [VLW-1:0]   w_rem;
    logic [VLW-1:0]   w_remBytes;
    logic             w_full;
    logic             w_fracCur;
    logic             w_last;
    logic             w_valid;
    logic [VLENB-1:0] w_byteEn;

    // Start-time decode: beat count and legality of the incoming configuration.
    always_comb begin
        w_eprIn     = BYTES >> vsew_i[1:0];
        w_beatsIn   = (vl_i + w_eprIn - ONE) >> (LB - int'(vsew_i[1:0]));
        if (vlmul_i[2])
            w_beatsIn = ONE;
        w_alignMask = vlmul_i[2] ? 5'd0 : (5'd1 << vlmul_i[1:0]) - 5'd1;
        w_illegalIn = vill_i || vsew_i[2] || (vlmul_i == 3'd4) ||
                      (|((vd_i | vs1_i | vs2_i) & w_alignMask));
    end

    // Per-beat tail mask: full body until the remaining elements fit in one register.
    always_comb begin
        w_eprCur   = BYTES >> r_vsew;
        w_rem      = r_vl - (r_idx << (LB - int'(r_vsew)));
        w_full     = (w_rem >= w_eprCur);
        w_remBytes = w_rem << r_vsew;
        w_byteEn   = '0;
        for (int b = 0; b < VLENB; b++)
            w_byteEn[b] = w_full || (VLW'(b) < w_remBytes);
        w_fracCur  = r_vlmul[2] && (r_vlmul[1:0] != 2'b00);
        w_last     = w_fracCur || (r_idx == r_beats - ONE);
    end

    assign w_valid       = (r_state == ISSUE);
    assign issue_valid_o = w_valid;
    assign vd_o          = w_valid ? r_vd  + r_idx[4:0] : 5'd0;
    assign vs1_o         = w_valid ? r_vs1 + r_idx[4:0] : 5'd0;
    assign vs2_o         = w_valid ? r_vs2 + r_idx[4:0] : 5'd0;
    assign byte_en_o     = w_valid ? w_byteEn : '0;
    assign first_o       = w_valid && (r_idx == '0);
    assign last_o        = w_valid && w_last;
    assign busy_o        = (r_state != IDLE);
    assign done_o        = (r_state == FINISH);
    assign illegal_o     = (r_state == FINISH) && r_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_vsew    <= '0;
            r_vlmul   <= '0;
            r_vl      <= '0;
            r_vd      <= '0;
            r_vs1     <= '0;
            r_vs2     <= '0;
            r_idx     <= '0;
            r_beats   <= '0;
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            r_state   <= IDLE;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_vsew    <= vsew_i;
                        r_vlmul   <= vlmul_i;
                        r_vl      <= vl_i;
                        r_vd      <= vd_i;
                        r_vs1     <= vs1_i;
                        r_vs2     <= vs2_i;
                        r_idx     <= '0;
                        r_beats   <= w_beatsIn;
                        r_illegal <= w_illegalIn;
                        r_state   <= (w_illegalIn || (vl_i == '0)) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_ready_i) begin
                        r_idx <= r_idx + ONE;
                        if (w_last)
                            r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_state   <= IDLE;
                    r_illegal <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VECTOR_SEQ_STALL_CNT_EN
    logic [31:0] r_stallCnt;

    // Saturating count of cycles the ALU back-pressures a valid beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stallCnt <= '0;
        else if (w_valid && !issue_ready_i && (r_stallCnt != '1))
            r_stallCnt <= r_stallCnt + 32'd1;
    end

    assign stall_cnt_o = r_stallCnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
